// File: rtl/digit_scan_ctrl.sv
// Four-digit time-multiplexed scan controller with a double-buffered frame port.
// Frames offered on upd_* are held in a pending buffer and swapped in only between frames.
module digit_scan_ctrl #(
  parameter int PRESCALE = 4,
  parameter int BLANK    = 1,
  parameter int DW       = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            upd_valid,
  output logic            upd_ready,
  input  logic [4*DW-1:0] upd_data,
  output logic            sel_a,
  output logic            sel_b,
  output logic [DW-1:0]   digit_out,
  output logic            blank,
  output logic            frame_start
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0]   presc_q, presc_d;
  logic [1:0]      idx_q, idx_d;
  logic [4*DW-1:0] active_q, active_d;
  logic [4*DW-1:0] pending_q, pending_d;
  logic            pend_full_q, pend_full_d;
  logic            frame_start_q, frame_start_d;
  logic            en_q, en_d;
  logic            wrap;
  logic            in_blank;

  always_comb begin
    presc_d       = presc_q;
    idx_d         = idx_q;
    active_d      = active_q;
    pending_d     = pending_q;
    pend_full_d   = pend_full_q;
    en_d          = en;
    wrap          = en && (idx_q == 2'd3) && (presc_q == PMAX);
    frame_start_d = wrap;

    if (en) begin
      if (presc_q == PMAX) begin
        presc_d = '0;
        idx_d   = idx_q + 2'd1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    // Commit and accept are mutually exclusive: accept needs an empty pending buffer.
    if (pend_full_q && (wrap || !en)) begin
      active_d    = pending_q;
      pend_full_d = 1'b0;
    end else if (upd_valid && !pend_full_q) begin
      pending_d   = upd_data;
      pend_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q       <= '0;
      idx_q         <= '0;
      active_q      <= '0;
      pending_q     <= '0;
      pend_full_q   <= 1'b0;
      frame_start_q <= 1'b0;
      en_q          <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      active_q      <= active_d;
      pending_q     <= pending_d;
      pend_full_q   <= pend_full_d;
      frame_start_q <= frame_start_d;
      en_q          <= en_d;
    end
  end

  generate
    if (BLANK == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (presc_q < PW'(BLANK));
    end
  endgenerate

  assign sel_a       = idx_q[1];
  assign sel_b       = idx_q[0];
  assign digit_out   = active_q[idx_q*DW +: DW];
  assign blank       = !en_q || in_blank;
  assign upd_ready   = !pend_full_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Bench for digit_scan_ctrl: directed scenarios then random traffic, checked every cycle
// against a frame-position model (cycle number within a 4*PRESCALE frame).
module tb_digit_scan_ctrl;
  localparam int P  = 4;
  localparam int B  = 1;
  localparam int DW = 4;
  localparam int FL = 4 * P;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_data = '0;
  logic        upd_ready, sel_a, sel_b, blank, frame_start;
  logic [3:0]  digit_out;
  logic [3:0]  dec;

  int checks = 0;
  int failures = 0;

  int          m_pos;
  bit          m_enq, m_full, m_fs;
  logic [15:0] m_act, m_pend;

  digit_scan_ctrl #(.PRESCALE(P), .BLANK(B), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_data(upd_data), .sel_a(sel_a), .sel_b(sel_b), .digit_out(digit_out),
    .blank(blank), .frame_start(frame_start)
  );

  // decoder_2x4 stand-in: a is the index MSB, b the LSB
  assign dec = 4'b0001 << {sel_a, sel_b};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int slot;
    slot = m_pos / P;
    chk("sel", 16'({sel_a, sel_b}), 16'(slot));
    chk("onehot", 16'(dec), 16'(1 << slot));
    chk("digit_out", 16'(digit_out), (m_act >> (DW * slot)) & 16'h000F);
    chk("blank", 16'(blank), 16'(!m_enq || ((m_pos % P) < B)));
    chk("upd_ready", 16'(upd_ready), 16'(!m_full));
    chk("frame_start", 16'(frame_start), 16'(m_fs));
  endtask

  task automatic step(input logic r, input logic e, input logic v, input logic [15:0] d);
    bit wrap, commit, accept;
    rst_n = r; en = e; upd_valid = v; upd_data = d;
    @(posedge clk);
    if (!r) begin
      m_pos = 0; m_enq = 0; m_full = 0; m_fs = 0; m_act = '0; m_pend = '0;
    end else begin
      wrap   = e && (m_pos == FL - 1);
      commit = m_full && (wrap || !e);
      accept = v && !m_full;
      m_fs   = wrap;
      if (e) m_pos = (m_pos + 1) % FL;
      if (commit) begin m_act = m_pend; m_full = 0; end
      if (accept) begin m_pend = d; m_full = 1; end
      m_enq = e;
    end
    #1;
    check_all();
  endtask

  initial begin
    bit          v;
    bit          r, e, was_ready;
    logic [15:0] d;
    m_pos = 0; m_enq = 0; m_full = 0; m_fs = 0; m_act = '0; m_pend = '0;

    // reset for two edges
    step(0, 0, 0, '0);
    step(0, 0, 0, '0);
    chk("reset_digit", 16'(digit_out), 16'h0);
    chk("reset_ready", 16'(upd_ready), 16'h1);

    // load 4321 while frozen: accept then immediate commit
    step(1, 0, 1, 16'h4321);
    step(1, 0, 0, '0);
    chk("loaded_digit0", 16'(digit_out), 16'h1);

    // scan two full frames, then reach slot 1
    for (int i = 0; i < 2 * FL + P; i++) step(1, 1, 0, '0);

    // mid-frame update, then back-pressure with a second frame
    step(1, 1, 1, 16'hABCD);
    chk("busy_after_accept", 16'(upd_ready), 16'h0);
    for (int i = 0; i < 4 * FL; i++) begin
      was_ready = !m_full;
      step(1, 1, 1, 16'h5555);
      if (was_ready) break;
    end
    chk("second_frame_pending", 16'(upd_ready), 16'h0);
    chk("abcd_active", m_act, 16'hABCD);

    // advance into slot 2 and freeze for 6 cycles
    for (int i = 0; i < 2 * FL && m_pos != 2 * P + 1; i++) step(1, 1, 0, '0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, '0);
    chk("freeze_commit", m_act, 16'h5555);
    for (int i = 0; i < 3; i++) step(1, 1, 0, '0);

    // pending frame, then reset during slot 3
    step(1, 1, 1, 16'h1357);
    for (int i = 0; i < 2 * FL && m_pos != 3 * P + 1; i++) step(1, 1, 0, '0);
    step(0, 1, 0, '0);
    step(1, 0, 0, '0);
    chk("post_reset_digit", 16'(digit_out), 16'h0);

    // random traffic; upstream holds valid/data until accepted
    v = 0; d = '0;
    for (int i = 0; i < 600; i++) begin
      if (!v && $urandom_range(0, 3) == 0) begin
        v = 1;
        d = 16'($urandom);
      end
      r = ($urandom_range(0, 99) != 0);
      e = ($urandom_range(0, 7) != 0);
      was_ready = !m_full;
      step(r, e, v, d);
      if (!r || (v && was_ready)) v = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
